// File: rtl/rom_sequencer_pkg.sv
// rom_sequencer_pkg: shared types and helpers for the ROM-to-LCD sequencer.
// Provides the FSM state type and the watchdog counter width helper.
package rom_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FREE,
      PRESENT
   } state_t;

   localparam int unsigned DEF_TIMEOUT = 1024;

   // Width able to hold 0..cycles; never narrower than one bit.
   function automatic int unsigned wd_width(input int unsigned cycles);
      return (cycles == 0) ? 1 : $clog2(cycles + 1);
   endfunction

   localparam int unsigned DEF_WD_W = wd_width(DEF_TIMEOUT);

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: clearable, enable-gated up-counter with terminal flag.
// Ports: clock, internal_reset_n, clear, enable -> expired.
module seq_watchdog
   import rom_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic clock,
   input  logic internal_reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = wd_width(TIMEOUT_CYCLES);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_wd;
         assign unused_wd = &{1'b0, clock, internal_reset_n, clear, enable};
         assign expired = 1'b0;
      end else begin : g_on
         localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES);
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
         logic [CW-1:0] count;

         always_ff @(posedge clock or negedge internal_reset_n) begin
            if (!internal_reset_n) begin
               count <= '0;
            end else if (clear) begin
               count <= '0;
            end else if (enable && count != TERM) begin
               count <= count + CW'(1);
            end
         end

         // Asserted during the cycle whose closing edge makes the
         // count reach TIMEOUT_CYCLES.
         assign expired = enable && (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/rom_sequencer.sv
// rom_sequencer: steps a ROM address window and hands words to the LCD.
// In: clock, internal_reset_n, start, abort, loop_mode, first/last_addr,
//     rom_data, lcd_busy. Out: rom_address, data_out, data_ready,
//     running, done, timeout.
module rom_sequencer
   import rom_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic                  clock,
   input  logic                  internal_reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  loop_mode,
   input  logic [ADDR_WIDTH-1:0] first_addr,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  lcd_busy,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_ready,
   output logic                  running,
   output logic                  done,
   output logic                  timeout
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] first_q;
   logic [ADDR_WIDTH-1:0] last_q;
   logic                  wd_expired;

   // Counter only runs while a word waits for acceptance; any other
   // state holds it at zero so each PRESENT starts from a fresh count.
   seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock           (clock),
      .internal_reset_n(internal_reset_n),
      .clear           (state != PRESENT),
      .enable          (state == PRESENT),
      .expired         (wd_expired)
   );

   always_ff @(posedge clock or negedge internal_reset_n) begin
      if (!internal_reset_n) begin
         state       <= IDLE;
         first_q     <= '0;
         last_q      <= '0;
         rom_address <= '0;
         data_out    <= '0;
         data_ready  <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state      <= IDLE;
            data_ready <= 1'b0;
            running    <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     first_q     <= first_addr;
                     last_q      <= last_addr;
                     rom_address <= first_addr;
                     timeout     <= 1'b0;
                     running     <= 1'b1;
                     state       <= WAIT_FREE;
                  end
               end
               WAIT_FREE: begin
                  if (!lcd_busy) begin
                     data_out   <= rom_data;
                     data_ready <= 1'b1;
                     state      <= PRESENT;
                  end
               end
               PRESENT: begin
                  if (lcd_busy) begin
                     data_ready <= 1'b0;
                     if (rom_address != last_q) begin
                        rom_address <= rom_address + ADDR_WIDTH'(1);
                        state       <= WAIT_FREE;
                     end else if (loop_mode) begin
                        rom_address <= first_q;
                        state       <= WAIT_FREE;
                     end else begin
                        done    <= 1'b1;
                        running <= 1'b0;
                        state   <= IDLE;
                     end
                  end else if (wd_expired) begin
                     timeout    <= 1'b1;
                     data_ready <= 1'b0;
                     running    <= 1'b0;
                     state      <= IDLE;
                  end
               end
               default: begin
                  data_ready <= 1'b0;
                  running    <= 1'b0;
                  state      <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: scoreboard bench for rom_sequencer with an LCD model.
// Words are queued as expected at start; a monitor checks each presentation.
module tb_rom_sequencer;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clock = 1'b0;
   logic          internal_reset_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          loop_mode = 1'b0;
   logic [AW-1:0] first_addr = '0;
   logic [AW-1:0] last_addr = '0;
   logic [DW-1:0] rom_data;
   logic          lcd_busy = 1'b0;
   logic [AW-1:0] rom_address;
   logic [DW-1:0] data_out;
   logic          data_ready;
   logic          running;
   logic          done;
   logic          timeout;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   pres_cnt = 0;
   int   done_cnt = 0;
   int   lcd_mode = 0;
   int   busy_cnt = 0;
   logic dr_prev = 1'b0;
   logic done_prev = 1'b0;

   rom_sequencer #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock           (clock),
      .internal_reset_n(internal_reset_n),
      .start           (start),
      .abort           (abort),
      .loop_mode       (loop_mode),
      .first_addr      (first_addr),
      .last_addr       (last_addr),
      .rom_data        (rom_data),
      .lcd_busy        (lcd_busy),
      .rom_address     (rom_address),
      .data_out        (data_out),
      .data_ready      (data_ready),
      .running         (running),
      .done            (done),
      .timeout         (timeout)
   );

   // Character ROM: word at address a is 0x40 + a.
   assign rom_data = 8'h40 + {4'h0, rom_address};

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every rising data_ready is one presented word.
   always @(negedge clock) begin
      if (data_ready && !dr_prev) begin
         pres_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got addr %0h data %0h want none",
                     rom_address, data_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("word_addr", 32'(rom_address), 32'(e.a));
            chk("word_data", 32'(data_out), 32'(e.d));
         end
      end
      if (done) begin
         done_cnt++;
         chk("done_idle", 32'(running), 32'd0);
         chk("done_width", 32'(done_prev), 32'd0);
      end
      dr_prev = data_ready;
      done_prev = done;
   end

   // LCD model: 0 = accept then busy 3 more cycles, 1 = busy, 2 = idle.
   always @(negedge clock) begin
      case (lcd_mode)
         1: begin
            lcd_busy = 1'b1;
            busy_cnt = 0;
         end
         2: begin
            lcd_busy = 1'b0;
            busy_cnt = 0;
         end
         default: begin
            if (busy_cnt != 0) begin
               busy_cnt--;
               lcd_busy = (busy_cnt != 0);
            end else if (data_ready) begin
               lcd_busy = 1'b1;
               busy_cnt = 4;
            end else begin
               lcd_busy = 1'b0;
            end
         end
      endcase
   end

   task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l,
                           input logic lp);
      @(negedge clock);
      first_addr = f;
      last_addr = l;
      loop_mode = lp;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (running && n < 400) begin
         @(negedge clock);
         n++;
      end
      chk(name, 32'(running), 32'd0);
      @(negedge clock);
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!data_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk(name, 32'(data_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      int base_p;
      int base_d;
      int n;
      int bad;
      int hi;

      repeat (3) @(negedge clock);
      chk("rst_addr", 32'(rom_address), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_ready", 32'(data_ready), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      internal_reset_n = 1'b1;

      // One-shot window 2..5
      lcd_mode = 0;
      push(4'd2, 8'h42);
      push(4'd3, 8'h43);
      push(4'd4, 8'h44);
      push(4'd5, 8'h45);
      base_p = pres_cnt;
      base_d = done_cnt;
      do_start(4'd2, 4'd5, 1'b0);
      chk("a_start_addr", 32'(rom_address), 32'd2);
      chk("a_running", 32'(running), 32'd1);
      chk("a_ready_low", 32'(data_ready), 32'd0);
      wait_idle("a_finish");
      chk("a_words", 32'(pres_cnt - base_p), 32'd4);
      chk("a_done", 32'(done_cnt - base_d), 32'd1);
      chk("a_last_addr", 32'(rom_address), 32'd5);
      chk("a_queue", 32'(exp_q.size()), 32'd0);

      // Looping wrapped window 14..1, two passes, then abort
      for (int p = 0; p < 2; p++) begin
         push(4'd14, 8'h4E);
         push(4'd15, 8'h4F);
         push(4'd0, 8'h40);
         push(4'd1, 8'h41);
      end
      base_p = pres_cnt;
      base_d = done_cnt;
      do_start(4'd14, 4'd1, 1'b1);
      n = 0;
      while (pres_cnt - base_p < 8 && n < 400) begin
         @(negedge clock);
         n++;
      end
      chk("b_words", 32'(pres_cnt - base_p), 32'd8);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("b_abort_ready", 32'(data_ready), 32'd0);
      chk("b_abort_running", 32'(running), 32'd0);
      chk("b_abort_addr", 32'(rom_address), 32'd14);
      @(negedge clock);
      chk("b_no_done", 32'(done_cnt - base_d), 32'd0);
      chk("b_queue", 32'(exp_q.size()), 32'd0);

      // LCD busy for 50 cycles after start
      @(negedge clock);
      lcd_mode = 1;
      push(4'd7, 8'h47);
      base_d = done_cnt;
      do_start(4'd7, 4'd7, 1'b0);
      bad = 0;
      repeat (50) begin
         @(negedge clock);
         if (data_ready || rom_address != 4'd7) bad++;
      end
      chk("c_hold", 32'(bad), 32'd0);
      lcd_mode = 0;
      n = 0;
      do begin
         @(posedge clock);
         n++;
      end while (lcd_busy && n < 10);
      #1;
      chk("c_present", 32'(data_ready), 32'd1);
      chk("c_word", 32'(data_out), 32'h47);
      wait_idle("c_finish");
      chk("c_done", 32'(done_cnt - base_d), 32'd1);
      chk("c_addr", 32'(rom_address), 32'd7);

      // LCD never accepts: timeout after 16 presenting cycles
      @(negedge clock);
      lcd_mode = 2;
      push(4'd3, 8'h43);
      base_d = done_cnt;
      do_start(4'd3, 4'd4, 1'b0);
      n = 0;
      hi = 0;
      while (running && n < 100) begin
         if (data_ready) hi++;
         @(negedge clock);
         n++;
      end
      chk("d_high_cycles", 32'(hi), 32'd16);
      chk("d_timeout", 32'(timeout), 32'd1);
      chk("d_running", 32'(running), 32'd0);
      @(negedge clock);
      chk("d_no_done", 32'(done_cnt - base_d), 32'd0);
      lcd_mode = 0;
      push(4'd9, 8'h49);
      base_d = done_cnt;
      do_start(4'd9, 4'd9, 1'b0);
      chk("d_timeout_clear", 32'(timeout), 32'd0);
      wait_idle("d_finish");
      chk("d_done", 32'(done_cnt - base_d), 32'd1);

      // start during PRESENT and start+abort in IDLE are ignored
      @(negedge clock);
      lcd_mode = 2;
      push(4'd0, 8'h40);
      push(4'd1, 8'h41);
      base_d = done_cnt;
      do_start(4'd0, 4'd1, 1'b0);
      wait_ready("e_present");
      do_start(4'd10, 4'd12, 1'b0);
      chk("e_addr_hold", 32'(rom_address), 32'd0);
      lcd_mode = 0;
      wait_idle("e_finish");
      chk("e_last_addr", 32'(rom_address), 32'd1);
      chk("e_done", 32'(done_cnt - base_d), 32'd1);
      @(negedge clock);
      first_addr = 4'd6;
      last_addr = 4'd8;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      chk("e_sa_running", 32'(running), 32'd0);
      chk("e_sa_addr", 32'(rom_address), 32'd1);

      // Reset while a word is presented
      @(negedge clock);
      lcd_mode = 2;
      push(4'd5, 8'h45);
      base_d = done_cnt;
      do_start(4'd5, 4'd6, 1'b0);
      wait_ready("r_present");
      @(negedge clock);
      internal_reset_n = 1'b0;
      #1;
      chk("r_addr", 32'(rom_address), 32'd0);
      chk("r_data", 32'(data_out), 32'd0);
      chk("r_ready", 32'(data_ready), 32'd0);
      chk("r_running", 32'(running), 32'd0);
      chk("r_done", 32'(done), 32'd0);
      chk("r_timeout", 32'(timeout), 32'd0);
      @(negedge clock);
      internal_reset_n = 1'b1;
      lcd_mode = 0;
      repeat (3) @(negedge clock);
      chk("r_no_done", 32'(done_cnt - base_d), 32'd0);
      chk("r_idle", 32'(running), 32'd0);
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_sequencer.md
# rom_sequencer

Parametrised ROM-to-LCD sequencer that steps a configurable address window of a character ROM and hands each word to the LCD driver through a busy/ready handshake. It sits between the LCD driver and the ROM, in place of the single-shot fixed-range controller. Additions over that controller:
- programmable first/last address
- one-shot or looping playback
- explicit start/abort
- done pulse
- LCD acceptance timeout

## Interface
Parameters:
- ADDR_WIDTH, 4, ROM address width
- DATA_WIDTH, 8, ROM word / LCD data width
- TIMEOUT_CYCLES, 1024, max cycles in PRESENT waiting for lcd_busy to rise; 0 disables timeout

Ports:
- clock  in  1  system clock, all logic on rising edge
- internal_reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin playback, honoured only in IDLE
- abort  in  1  forces return to IDLE from any state
- loop_mode  in  1  1 = wrap from last_addr to first_addr indefinitely; sampled on every last-entry accept
- first_addr  in  ADDR_WIDTH  first entry, latched on start
- last_addr  in  ADDR_WIDTH  last entry, latched on start
- rom_data  in  DATA_WIDTH  ROM word, combinational read of rom_address
- lcd_busy  in  1  LCD driver busy flag, same clock domain
- rom_address  out  ADDR_WIDTH  current ROM address
- data_out  out  DATA_WIDTH  registered word presented to LCD
- data_ready  out  1  data_out valid, LCD may consume
- running  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a one-shot pass completes
- timeout  out  1  sticky error, cleared by next accepted start or reset

## Operation
- Reset (async, internal_reset_n low): state IDLE; rom_address=0, data_out=0, data_ready=0, running=0, done=0, timeout=0, latched window=0, timeout counter=0.
- IDLE: on start (and not abort), latch first_addr/last_addr, set rom_address=first_addr, clear timeout, go WAIT_FREE.
- WAIT_FREE: data_ready=0. When lcd_busy==0, register data_out<=rom_data, set data_ready=1, clear timeout counter, go PRESENT. This also blocks output while the LCD initialises (busy held high).
- PRESENT: data_ready=1, data_out held. When lcd_busy==1 (word accepted):
  - data_ready<=0.
  - If rom_address != last: rom_address+1 (mod 2^ADDR_WIDTH), go WAIT_FREE.
  - If rom_address == last and loop_mode=1: rom_address<=first, go WAIT_FREE.
  - If rom_address == last and loop_mode=0: pulse done, go IDLE; rom_address holds last.
- Timeout: counter increments each PRESENT cycle. Reaching TIMEOUT_CYCLES without acceptance sets timeout=1, data_ready<=0, go IDLE. No done pulse.
- Abort has priority over all transitions: data_ready<=0, go IDLE, rom_address and data_out hold, no done.
- start outside IDLE is ignored. Same-cycle start+abort in IDLE: abort wins, stay IDLE.
- Window wrap: last<first plays first..2^ADDR_WIDTH-1, 0..last. first==last plays one entry per pass.

## Timing
- start sampled at edge k: rom_address=first and running=1 after k. If lcd_busy low at edge k+1, data_ready=1 and data_out valid after k+1.
- Accept seen at edge m: data_ready low and address advanced after m. Next data_ready no earlier than edge m+1, even if busy is already low.
- data_ready is never high in two consecutive words without an intervening low cycle.
- done is high exactly one cycle, coincident with the first IDLE cycle.
- Timeout fires at the edge where the counter equals TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after data_ready rose.

## Structure
- Package rom_sequencer_pkg:
  - typedef enum state_t {IDLE, WAIT_FREE, PRESENT}
  - timeout counter width constant derived via $clog2(TIMEOUT_CYCLES+1)
- Sub-module seq_watchdog:
  - Function: clearable, enable-gated up-counter with a terminal flag, parameterised by TIMEOUT_CYCLES.
  - Ports: clock, internal_reset_n, clear, enable, expired.
- Next-state logic, address increment and wrap live in rom_sequencer.

## Test plan
- Reset mid-PRESENT (internal_reset_n low for 1 cycle) -> all outputs 0 immediately, state IDLE, no done.
- first=2, last=5, loop_mode=0, LCD model busy for 3 cycles after each accept -> data_out sequence ROM[2..5], exactly 4 data_ready pulses, single done, rom_address=5 afterwards.
- ADDR_WIDTH=4, first=14, last=1, loop_mode=1 for 2 passes -> addresses 14,15,0,1,14,15,0,1; done never asserted; abort then returns to IDLE with data_ready=0.
- lcd_busy held high 50 cycles after start -> data_ready stays 0 and rom_address=first throughout; word ROM[first] presented on the first cycle after busy falls.
- TIMEOUT_CYCLES=16, LCD never raises busy -> data_ready high for 16 cycles, then timeout=1 and IDLE; the next start clears timeout.
- start asserted during PRESENT, and start+abort together in IDLE -> both ignored, latched window unchanged.
